// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and helpers for the program-counter unit
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_JUMP   = 2'd1,
        PC_BRANCH = 2'd2,
        PC_RET    = 2'd3
    } pc_sel_e;

    // Width of the return-address stack pointer for a given depth.
    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular LIFO return-address stack with overflow/underflow flag
module pc_ras
    import pc_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         err
);

    localparam int PTR_W = ras_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [CNT_W-1:0] count;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign top   = mem[wptr - PTR_W'(1)];

    // Entries live in a ring; a push on a full stack silently replaces the
    // oldest entry so the DEPTH most recent return addresses survive.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (push) begin
            mem[wptr] <= data_in;
            wptr      <= wptr + PTR_W'(1);
            if (full) begin
                err <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                err <= 1'b1;
            end else begin
                wptr  <= wptr - PTR_W'(1);
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with jump, relative branch and call/return stack
module pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = 8,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            stall,
    input  logic [1:0]      PCsrc,
    input  logic            call,
    input  logic [PC_W-1:0] immediate,
    output logic [PC_W-1:0] PC,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_err
);

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] ras_top;
    logic            push;
    logic            pop;

    // Both adders wrap modulo 2^PC_W; the branch offset is two's complement
    // so a plain add of equal widths gives the signed result.
    assign pc_inc = PC + PC_W'(1);
    assign pc_br  = PC + immediate;

    // Next-PC select and stack control; a stall freezes both PC and stack.
    always_comb begin
        pc_next = PC;
        push    = 1'b0;
        pop     = 1'b0;
        if (!stall) begin
            case (pc_sel_e'(PCsrc))
                PC_SEQ: begin
                    pc_next = pc_inc;
                end
                PC_JUMP: begin
                    pc_next = immediate;
                    push    = call;
                end
                PC_BRANCH: begin
                    pc_next = pc_br;
                    push    = call;
                end
                PC_RET: begin
                    pop     = 1'b1;
                    pc_next = ras_empty ? pc_inc : ras_top;
                end
                default: pc_next = pc_inc;
            endcase
        end
    end

    // PC register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            PC <= RESET_VEC;
        end else begin
            PC <= pc_next;
        end
    end

    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (CLK),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .data_in (pc_inc),
        .top     (ras_top),
        .empty   (ras_empty),
        .full    (ras_full),
        .err     (ras_err)
    );

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit against a queue-based model
module tb_pc_unit;

    logic       CLK;
    logic       reset;
    logic       stall;
    logic [1:0] PCsrc;
    logic       call;
    logic [7:0] immediate;
    logic [7:0] PC;
    logic       ras_empty;
    logic       ras_full;
    logic       ras_err;
    logic [7:0] pc_b;
    logic       empty_b;
    logic       full_b;
    logic       err_b;

    int checks = 0;
    int errors = 0;

    int m_pc  = 0;
    int m_err = 0;
    int m_stk[$];

    pc_unit dut (
        .CLK       (CLK),
        .reset     (reset),
        .stall     (stall),
        .PCsrc     (PCsrc),
        .call      (call),
        .immediate (immediate),
        .PC        (PC),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
    );

    pc_unit #(.RESET_VEC(8'h40)) dut_rv (
        .CLK       (CLK),
        .reset     (reset),
        .stall     (stall),
        .PCsrc     (PCsrc),
        .call      (call),
        .immediate (immediate),
        .PC        (pc_b),
        .ras_empty (empty_b),
        .ras_full  (full_b),
        .ras_err   (err_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input int v);
        if (m_stk.size() == 4) begin
            void'(m_stk.pop_front());
            m_err = 1;
        end
        m_stk.push_back(v);
    endtask

    task automatic cycle(input bit r, input bit st, input int src, input bit cl, input int imm);
        reset     = r;
        stall     = st;
        PCsrc     = 2'(src);
        call      = cl;
        immediate = 8'(imm);
        @(posedge CLK);
        if (r) begin
            m_pc = 0;
            m_stk.delete();
            m_err = 0;
        end else if (!st) begin
            case (src)
                0: m_pc = (m_pc + 1) % 256;
                1: begin
                    if (cl) model_push((m_pc + 1) % 256);
                    m_pc = imm % 256;
                end
                2: begin
                    if (cl) model_push((m_pc + 1) % 256);
                    m_pc = (m_pc + imm) % 256;
                end
                default: begin
                    if (m_stk.size() == 0) begin
                        m_err = 1;
                        m_pc  = (m_pc + 1) % 256;
                    end else begin
                        m_pc = m_stk.pop_back();
                    end
                end
            endcase
        end
        #1;
        check_eq("pc", int'(PC), m_pc);
        check_eq("ras_empty", int'(ras_empty), int'(m_stk.size() == 0));
        check_eq("ras_full", int'(ras_full), int'(m_stk.size() == 4));
        check_eq("ras_err", int'(ras_err), m_err);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; PCsrc = 2'd0; call = 1'b0; immediate = 8'h00;

        // reset and sequential counting
        cycle(1, 0, 0, 0, 0);
        check_eq("reset_pc", int'(PC), 0);
        check_eq("reset_vec", int'(pc_b), 8'h40);
        check_eq("reset_empty", int'(ras_empty), 1);
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 0, 0, 0, 0);
            check_eq("seq_pc", int'(PC), i);
        end

        // jump, negative branch, wrap
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_eq("at5", int'(PC), 5);
        cycle(0, 0, 1, 0, 8'h10);
        check_eq("jump", int'(PC), 8'h10);
        cycle(0, 0, 2, 0, 8'hFE);
        check_eq("branch_neg", int'(PC), 8'h0E);
        cycle(0, 0, 1, 0, 8'hFF);
        cycle(0, 0, 0, 0, 0);
        check_eq("wrap", int'(PC), 8'h00);

        // call and return
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 8'h20);
        check_eq("call_pc", int'(PC), 8'h20);
        check_eq("call_empty", int'(ras_empty), 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 3, 0, 0);
        check_eq("ret_pc", int'(PC), 8'h04);
        check_eq("ret_empty", int'(ras_empty), 1);

        // stall holds everything, release acts once
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, 1, 8'h30);
            check_eq("stall_pc", int'(PC), 8'h04);
            check_eq("stall_empty", int'(ras_empty), 1);
        end
        cycle(0, 0, 1, 1, 8'h30);
        check_eq("unstall_pc", int'(PC), 8'h30);
        cycle(0, 0, 3, 0, 0);
        check_eq("unstall_ret", int'(PC), 8'h05);
        check_eq("unstall_once", int'(ras_empty), 1);

        // overflow: five calls into a four-entry stack
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 2; i <= 5; i++) cycle(0, 0, 1, 1, i);
        cycle(0, 0, 1, 1, 8'h60);
        check_eq("ovf_full", int'(ras_full), 1);
        check_eq("ovf_err", int'(ras_err), 1);
        for (int i = 6; i >= 3; i--) begin
            cycle(0, 0, 3, 0, 0);
            check_eq("ovf_ret", int'(PC), i);
        end
        check_eq("ovf_empty", int'(ras_empty), 1);

        // underflow, then reset with live entries
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 3, 0, 0);
        check_eq("unf_pc", int'(PC), 8);
        check_eq("unf_err", int'(ras_err), 1);
        cycle(0, 0, 1, 1, 8'h50);
        cycle(0, 0, 2, 1, 8'h03);
        cycle(1, 0, 3, 0, 0);
        check_eq("rst_mid_pc", int'(PC), 0);
        check_eq("rst_mid_vec", int'(pc_b), 8'h40);
        check_eq("rst_mid_empty", int'(ras_empty), 1);
        check_eq("rst_mid_err", int'(ras_err), 0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
                  int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the CPU front end; successor to the 8-bit increment/load PC.
- Supports configurable PC width and a reset vector.
- Adds a stall, four next-PC modes (sequential, absolute jump, PC-relative branch, return) and a hardware return-address stack (RAS) for call/return.
- Feeds instruction-memory address; driven by decode/control.

Parameters:
- PC_W, 8, width of PC, target and stack entries (min 4).
- RAS_DEPTH, 4, number of RAS entries (power of two, min 2).
- RESET_VEC, 0, PC value loaded on reset (PC_W bits).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and RAS unchanged this cycle.
- PCsrc  input  2  next-PC select: 0 SEQ, 1 JUMP (absolute), 2 BRANCH (relative), 3 RET.
- call  input  1  with JUMP or BRANCH: push return address PC+1 onto RAS.
- immediate  input  PC_W  absolute target (JUMP) or two's-complement offset (BRANCH).
- PC  output  PC_W  current program counter (registered).
- ras_empty  output  1  RAS holds no entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_err  output  1  sticky: set on push-while-full or pop-while-empty.

Behaviour:
- Reset (sync, highest priority): PC=RESET_VEC, RAS count=0, ras_empty=1, ras_full=0, ras_err=0. Reset mid-call/return discards all stack contents.
- stall=1 (and reset=0): PC, RAS and ras_err hold; PCsrc, call and immediate are ignored.
- Otherwise, next PC is chosen by PCsrc, updating one cycle after the inputs are sampled (latency 1, no bubbles):
  - SEQ: PC+1, mod 2^PC_W (wraps from all-ones to 0).
  - JUMP: immediate.
  - BRANCH: PC+immediate, immediate signed PC_W, result mod 2^PC_W.
  - RET: top of RAS, popped.
- call=1 with JUMP/BRANCH: pushes (PC+1) mod 2^PC_W in the same cycle as the redirect. call is ignored with SEQ and RET (no push).
- Push while full:
  - Entry is written anyway; the oldest entry is overwritten (circular stack, count stays RAS_DEPTH).
  - ras_err is set.
  - The jump/branch still occurs.
- RET while empty:
  - PC takes PC+1 (treated as SEQ).
  - Count stays 0; ras_err is set.
- Stack is LIFO with count-based top pointer: top = most recent push. After overflow, the RAS_DEPTH most recent pushes are retained.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH); both registered-state derived, valid same cycle as PC.
- ras_err clears only on reset.
- No combinational path from inputs to PC; ras_* outputs are functions of state only.

Decomposition:
- Package pc_pkg:
  - enum pc_sel_e {PC_SEQ=0, PC_JUMP=1, PC_BRANCH=2, PC_RET=3}, 2 bits.
  - Localparam helper for the RAS pointer width, $clog2(RAS_DEPTH).
- One sub-module, pc_ras:
  - Parametrised LIFO with push/pop/data_in/top/empty/full/err.
  - Circular overwrite on full, pop-on-empty flagged.
  - Push and pop are never asserted together by pc_unit.
- pc_unit holds the PC register, next-PC mux and the adder for SEQ/BRANCH.

Test Plan:
- Reset, then 3 cycles SEQ -> PC sequence 0,1,2,3; RESET_VEC=8'h40 build -> PC=8'h40 after reset.
- At PC=5, JUMP immediate=8'h10 -> PC=8'h10; at PC=8'h10, BRANCH immediate=8'hFE -> PC=8'h0E; at PC=8'hFF, SEQ -> PC=8'h00.
- At PC=3, JUMP+call immediate=8'h20 -> PC=8'h20, ras_empty=0; two SEQ then RET -> PC=8'h04, ras_empty=1.
- stall=1 for 3 cycles with PCsrc=JUMP, call=1 -> PC, ras_empty unchanged; release -> jump and push occur once.
- 5 call-jumps with RAS_DEPTH=4 from PCs 1,2,3,4,5 (immediate=next caller) -> ras_full=1, ras_err=1; 4 RETs -> PCs 6,5,4,3, then ras_empty=1.
- RET on empty at PC=7 -> PC=8, ras_err=1; reset mid-stack (2 entries) -> PC=RESET_VEC, ras_empty=1, ras_err=0.
